stg1fq: RTL and testbench

//   Parametrised instruction front end; replaces the free-running PC counter plus stg1ia/stg1if pair.

---
 rtl/stg1fq_pkg.sv | 14 +
 rtl/stg1fq_fifo_sync.sv | 83 ++++++++
 rtl/stg1fq.sv | 107 ++++++++++
 tb/tb_stg1fq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stg1fq_pkg.sv
// Shared sizing for the instruction fetch queue front end.
// Default widths stand in for the project-wide address/data/depth sizes.
package stg1fq_pkg;

    localparam int FQ_ADDR_W = 16;
    localparam int FQ_DATA_W = 32;
    localparam int FQ_DEPTH  = 4;

    // Occupancy counters need one extra bit so that "full" is representable.
    function automatic int fq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stg1fq_fifo_sync.sv
// Synchronous FIFO with flush, head read straight from storage, and occupancy count.
// A push and a pop in the same cycle leave the count unchanged.
module fifo_sync
    import stg1fq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            head_o,
    output logic                        valid_o,
    output logic [fq_cnt_w(DEPTH)-1:0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fq_cnt_w(DEPTH);

    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop_i & ~empty;
    // A push into a full queue is only legal when a pop frees a slot this cycle.
    assign push_ok = push_i & (~full | pop_ok);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                wr_d = wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_d = rd_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok & ~flush_i & ~rst_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign valid_o = ~empty;
    assign count_o = cnt_q;

endmodule

// File: rtl/stg1fq.sv
// Instruction fetch front end: owns the PC, issues single-cycle-latency reads and
// queues returned {pc,instr} pairs for decode, with redirect/flush and credit-limited prefetch.
module stg1fq
    import stg1fq_pkg::*;
#(
    parameter int                ADDR_W   = FQ_ADDR_W,
    parameter int                DATA_W   = FQ_DATA_W,
    parameter int                DEPTH    = FQ_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        iw_clk,
    input  logic                        iw_rst,
    output logic [ADDR_W-1:0]           ow_mem_addr,
    output logic                        ow_mem_re,
    input  logic [DATA_W-1:0]           iw_mem_data,
    input  logic                        iw_redir,
    input  logic [ADDR_W-1:0]           iw_redir_pc,
    output logic                        ow_valid,
    input  logic                        iw_ready,
    output logic [ADDR_W-1:0]           ow_pc,
    output logic [DATA_W-1:0]           ow_instr,
    output logic [fq_cnt_w(DEPTH)-1:0]  ow_count
);

    localparam int CW = fq_cnt_w(DEPTH);
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] issued_pc_q, issued_pc_d;
    logic              inflight_q, inflight_d;
    logic              tag_q, tag_d;
    logic              epoch_q, epoch_d;

    logic [EW-1:0]     fifo_head;
    logic              fifo_valid;
    logic [CW-1:0]     fifo_count;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CW:0]       occupancy;
    logic              issue;

    // A redirect discards the queue anyway, so popping in that cycle would hand decode a flushed entry.
    assign fifo_pop  = fifo_valid & iw_ready & ~iw_redir;

    // Reserve a slot for the outstanding read so its return can never overflow the queue.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, fifo_pop};
    assign issue     = ~iw_rst & ~iw_redir & (occupancy < (CW+1)'(DEPTH));

    // Returns tagged with an older epoch belong to a fetch stream that was redirected away.
    assign fifo_push = inflight_q & (tag_q == epoch_q) & ~iw_redir;

    always_comb begin
        pc_d        = pc_q;
        issued_pc_d = issued_pc_q;
        inflight_d  = issue;
        tag_d       = tag_q;
        epoch_d     = epoch_q;
        if (iw_redir) begin
            pc_d    = iw_redir_pc;
            epoch_d = ~epoch_q;
        end else if (issue) begin
            pc_d        = pc_q + 1'b1;
            issued_pc_d = pc_q;
            tag_d       = epoch_q;
        end
    end

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= 1'b0;
            epoch_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            issued_pc_q <= issued_pc_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            epoch_q     <= epoch_d;
        end
    end

    fifo_sync #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (iw_clk),
        .rst_i   (iw_rst),
        .flush_i (iw_redir),
        .push_i  (fifo_push),
        .data_i  ({issued_pc_q, iw_mem_data}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    assign ow_mem_addr = pc_q;
    assign ow_mem_re   = issue;
    assign ow_valid    = fifo_valid;
    assign ow_count    = fifo_count;
    // Storage is not reset, so present zeros rather than stale contents when empty.
    assign ow_pc       = fifo_valid ? fifo_head[EW-1:DATA_W] : '0;
    assign ow_instr    = fifo_valid ? fifo_head[DATA_W-1:0]  : '0;

endmodule

// File: tb/tb_stg1fq.sv
// Directed self-checking bench for stg1fq: reset, streaming, back-pressure, redirects,
// PC wrap and mid-stream reset against a memory whose word at address a is 0x100 + a.
module tb_stg1fq;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              iw_clk = 1'b0;
    logic              iw_rst = 1'b1;
    logic [ADDR_W-1:0] ow_mem_addr;
    logic              ow_mem_re;
    logic [DATA_W-1:0] iw_mem_data = '0;
    logic              iw_redir = 1'b0;
    logic [ADDR_W-1:0] iw_redir_pc = '0;
    logic              ow_valid;
    logic              iw_ready = 1'b0;
    logic [ADDR_W-1:0] ow_pc;
    logic [DATA_W-1:0] ow_instr;
    logic [CW-1:0]     ow_count;

    int checkCount = 0;
    int errorCount = 0;
    int issueCount = 0;

    stg1fq #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (8'h00)
    ) dut (
        .iw_clk      (iw_clk),
        .iw_rst      (iw_rst),
        .ow_mem_addr (ow_mem_addr),
        .ow_mem_re   (ow_mem_re),
        .iw_mem_data (iw_mem_data),
        .iw_redir    (iw_redir),
        .iw_redir_pc (iw_redir_pc),
        .ow_valid    (ow_valid),
        .iw_ready    (iw_ready),
        .ow_pc       (ow_pc),
        .ow_instr    (ow_instr),
        .ow_count    (ow_count)
    );

    always #5 iw_clk = ~iw_clk;

    // Instruction memory with one-cycle synchronous read latency.
    always @(posedge iw_clk) begin
        if (ow_mem_re) begin
            iw_mem_data <= {8'h01, ow_mem_addr};
        end
    end

    task automatic step();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic ready,
                                 input logic redir, input logic [ADDR_W-1:0] redirPc);
        iw_rst      = rst;
        iw_ready    = ready;
        iw_redir    = redir;
        iw_redir_pc = redirPc;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset state
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        step();
        step();
        settle();
        checkOutput("rst_valid", 32'(ow_valid), 32'h0);
        checkOutput("rst_count", 32'(ow_count), 32'h0);
        checkOutput("rst_pc",    32'(ow_pc),    32'h0);
        checkOutput("rst_instr", 32'(ow_instr), 32'h0);
        checkOutput("rst_re",    32'(ow_mem_re), 32'h0);

        // Streaming with decode always ready
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        checkOutput("t1_re_c0",    32'(ow_mem_re),   32'h1);
        checkOutput("t1_addr_c0",  32'(ow_mem_addr), 32'h0);
        checkOutput("t1_valid_c0", 32'(ow_valid),    32'h0);
        step();
        checkOutput("t1_valid_c1", 32'(ow_valid),    32'h0);
        checkOutput("t1_addr_c1",  32'(ow_mem_addr), 32'h1);
        step();
        checkOutput("t1_valid_c2", 32'(ow_valid), 32'h1);
        checkOutput("t1_pc_c2",    32'(ow_pc),    32'h0);
        checkOutput("t1_instr_c2", 32'(ow_instr), 32'h100);
        for (int i = 1; i <= 5; i++) begin
            step();
            checkOutput("t1_pc",    32'(ow_pc),    32'(i));
            checkOutput("t1_instr", 32'(ow_instr), 32'h100 + 32'(i));
            checkOutput("t1_count", 32'(ow_count), 32'h1);
        end

        // Back-pressure from a fresh reset: credits allow exactly DEPTH issues
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        issueCount = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (ow_mem_re) begin
                issueCount++;
            end
            if (ow_valid) begin
                checkOutput("t2_head_stable", 32'(ow_pc), 32'h0);
            end
            step();
        end
        settle();
        checkOutput("t2_issues", 32'(issueCount), 32'd4);
        checkOutput("t2_count",  32'(ow_count),   32'd4);
        checkOutput("t2_re",     32'(ow_mem_re),  32'h0);
        checkOutput("t2_pc",     32'(ow_pc),      32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_drain_valid", 32'(ow_valid), 32'h1);
            checkOutput("t2_drain_pc",    32'(ow_pc),    32'(i));
            checkOutput("t2_drain_instr", 32'(ow_instr), 32'h100 + 32'(i));
            step();
        end

        // Redirect with three queued entries and a read in flight
        settle();
        checkOutput("t3_count_before", 32'(ow_count), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h40);
        settle();
        checkOutput("t3_re_redir", 32'(ow_mem_re), 32'h0);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        checkOutput("t3_count_t1", 32'(ow_count),    32'h0);
        checkOutput("t3_valid_t1", 32'(ow_valid),    32'h0);
        checkOutput("t3_addr_t1",  32'(ow_mem_addr), 32'h40);
        checkOutput("t3_re_t1",    32'(ow_mem_re),   32'h1);
        step();
        checkOutput("t3_valid_t2", 32'(ow_valid), 32'h0);
        step();
        checkOutput("t3_valid_t3", 32'(ow_valid), 32'h1);
        checkOutput("t3_pc_t3",    32'(ow_pc),    32'h40);
        checkOutput("t3_instr_t3", 32'(ow_instr), 32'h140);
        step();
        checkOutput("t3_pc_t4", 32'(ow_pc), 32'h41);
        step();
        checkOutput("t3_pc_t5", 32'(ow_pc), 32'h42);

        // Back-to-back redirects: the later target wins
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h10);
        settle();
        checkOutput("t4_re_first", 32'(ow_mem_re), 32'h0);
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h20);
        settle();
        checkOutput("t4_valid_second", 32'(ow_valid),  32'h0);
        checkOutput("t4_re_second",    32'(ow_mem_re), 32'h0);
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        checkOutput("t4_addr", 32'(ow_mem_addr), 32'h20);
        checkOutput("t4_re",   32'(ow_mem_re),   32'h1);
        step();
        checkOutput("t4_valid_gap", 32'(ow_valid), 32'h0);
        step();
        checkOutput("t4_valid", 32'(ow_valid), 32'h1);
        checkOutput("t4_pc",    32'(ow_pc),    32'h20);
        checkOutput("t4_instr", 32'(ow_instr), 32'h120);
        for (int i = 1; i <= 3; i++) begin
            step();
            checkOutput("t4_pc_seq", 32'(ow_pc), 32'h20 + 32'(i));
        end

        // PC wraps modulo 2^ADDR_W
        step();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hFE);
        settle();
        step();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        checkOutput("t5_addr", 32'(ow_mem_addr), 32'hFE);
        step();
        step();
        checkOutput("t5_pc0",    32'(ow_pc),    32'hFE);
        checkOutput("t5_instr0", 32'(ow_instr), 32'h1FE);
        step();
        checkOutput("t5_pc1",    32'(ow_pc),    32'hFF);
        checkOutput("t5_instr1", 32'(ow_instr), 32'h1FF);
        step();
        checkOutput("t5_pc2",    32'(ow_pc),    32'h00);
        checkOutput("t5_instr2", 32'(ow_instr), 32'h100);
        step();
        checkOutput("t5_pc3",    32'(ow_pc),    32'h01);
        checkOutput("t5_instr3", 32'(ow_instr), 32'h101);

        // Reset while the queue is full
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step();
        end
        settle();
        checkOutput("t6_count_full", 32'(ow_count),  32'd4);
        checkOutput("t6_re_full",    32'(ow_mem_re), 32'h0);
        checkOutput("t6_valid_full", 32'(ow_valid),  32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        settle();
        checkOutput("t6_re_in_rst", 32'(ow_mem_re), 32'h0);
        step();
        checkOutput("t6_valid", 32'(ow_valid),    32'h0);
        checkOutput("t6_count", 32'(ow_count),    32'h0);
        checkOutput("t6_pc",    32'(ow_pc),       32'h0);
        checkOutput("t6_instr", 32'(ow_instr),    32'h0);
        checkOutput("t6_re",    32'(ow_mem_re),   32'h0);
        checkOutput("t6_addr",  32'(ow_mem_addr), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        checkOutput("t6_refetch_re",   32'(ow_mem_re),   32'h1);
        checkOutput("t6_refetch_addr", 32'(ow_mem_addr), 32'h0);
        step();
        step();
        checkOutput("t6_refetch_valid", 32'(ow_valid), 32'h1);
        checkOutput("t6_refetch_pc",    32'(ow_pc),    32'h0);
        checkOutput("t6_refetch_instr", 32'(ow_instr), 32'h100);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
